// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit 7-segment scanner.
// Holds the FSM state enum and the active-high hex segment table.
package seg_pkg;

  typedef enum logic {
    LOAD,
    SCAN
  } state_e;

  localparam logic [6:0] SEG_BLANK_AH = 7'h00;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_display_scan_if.sv
// Display bus between the CPU display outputs and the scanner.
// master: drives value/pc/show_pc; slave: drives an/seg/dp/frame_done.
interface seg_display_scan_if;
  logic [31:0] value_in;
  logic [14:0] pc_in;
  logic        show_pc;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output value_in, pc_in, show_pc,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  value_in, pc_in, show_pc,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg_display_scan_hex_to_seg7.sv
// Combinational nibble to active-high 7-segment pattern.
// Ports: nib (4-bit hex digit), seg_ah (pattern {g,f,e,d,c,b,a}).
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_ah
);

  assign seg_ah = HEX_SEG[nib];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 8-digit 7-segment scanner with per-frame snapshot.
// Ports: clk, rst (async high), io (slave: value/pc/show_pc in, an/seg/dp/frame_done out).
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int DIGITS         = 8,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg_display_scan_if.slave  io
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [2:0] LAST = 3'(DIGITS - 1);
  localparam logic AL = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = AL ? ~SEG_BLANK_AH : SEG_BLANK_AH;
  localparam logic DP_OFF = AL;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          src_pc_q, src_pc_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic [3:0]  nib;
  logic [6:0]  seg_ah;
  logic [6:0]  seg_lit;
  logic [2:0]  msd;
  logic        blank;
  logic        dp_on;
  logic [31:0] cap;

  assign nib = snap_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib    (nib),
    .seg_ah (seg_ah)
  );

  // Highest nonzero nibble; 0 when the whole snapshot is zero.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (snap_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end

  assign blank   = (LZ_BLANK != 0) && (idx_q > msd);
  assign seg_lit = blank ? SEG_BLANK_AH : seg_ah;
  assign dp_on   = (idx_q == 3'd0) && src_pc_q;
  assign cap     = io.show_pc ? {17'b0, io.pc_in} : io.value_in;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    src_pc_d = src_pc_q;
    an_d     = 8'hFF;
    seg_d    = SEG_OFF;
    dp_d     = DP_OFF;
    fd_d     = 1'b0;
    unique case (state_q)
      LOAD: begin
        snap_d   = cap;
        src_pc_d = io.show_pc;
        idx_d    = 3'd0;
        presc_d  = '0;
        state_d  = SCAN;
      end
      SCAN: begin
        an_d  = ~(8'b1 << idx_q);
        seg_d = AL ? ~seg_lit : seg_lit;
        dp_d  = dp_on ^ DP_OFF;
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (idx_q != LAST) begin
            idx_d = idx_q + 3'd1;
          end else begin
            // Recapture at the boundary so frames run back to back.
            idx_d    = 3'd0;
            fd_d     = 1'b1;
            snap_d   = cap;
            src_pc_d = io.show_pc;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      presc_q  <= '0;
      idx_q    <= 3'd0;
      snap_q   <= '0;
      src_pc_q <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      src_pc_q <= src_pc_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign io.an         = an_q;
  assign io.seg        = seg_q;
  assign io.dp         = dp_q;
  assign io.frame_done = fd_q;

endmodule
